// File: rtl/sme_param_pkg.sv
// Shared definitions for the sme_param string-match engine.
//   - ASCII codes for the pattern meta-characters and the word separator
//   - FSM state enum (also driven out on the top-level debug port)
//   - char_eq: character equality, case-folding or exact
// Build option: SME_CASE_FOLD_EN -- when defined, ASCII letters compare equal
// to their other case. When undefined, bytes are compared exactly and no
// folding logic exists.
package sme_pkg;

  localparam logic [7:0] CH_START = 8'h5E;  // '^' word-start anchor
  localparam logic [7:0] CH_END   = 8'h24;  // '$' word-end anchor
  localparam logic [7:0] CH_ANY   = 8'h2E;  // '.' any single character
  localparam logic [7:0] CH_SPACE = 8'h20;  // word separator

  typedef enum logic [2:0] {
    IDLE,
    LOAD_STR,
    LOAD_PAT,
    SEARCH,
    DONE
  } sme_state_e;

  // Characters are widened to 32 bits by the caller so one function serves
  // any CHAR_W.
`ifdef SME_CASE_FOLD_EN
  function automatic logic [31:0] fold_case(input logic [31:0] c);
    if (c >= 32'h41 && c <= 32'h5A) return c | 32'h20;
    return c;
  endfunction

  function automatic logic char_eq(input logic [31:0] a, input logic [31:0] b);
    return fold_case(a) == fold_case(b);
  endfunction
`else
  function automatic logic char_eq(input logic [31:0] a, input logic [31:0] b);
    return a == b;
  endfunction
`endif

  // Meta-character detection is always exact.
  function automatic logic is_code(input logic [31:0] c, input logic [7:0] code);
    return c == {24'h0, code};
  endfunction

endpackage

// File: rtl/sme_param_if.sv
// Host byte-stream interface of the string-match engine.
//   chardata    host -> engine  character
//   isstring    host -> engine  chardata is a subject-string character
//   ispattern   host -> engine  chardata is a pattern character
//   match       engine -> host  result is a match (qualified by valid)
//   match_index engine -> host  start index of the match, 0 on no match
//   valid       engine -> host  one-cycle result strobe
//   busy        engine -> host  searching / reporting
// Handshake: there is no ready signal. A character is taken on every clock
// where isstring or ispattern is high and busy is low; characters presented
// while busy is high are dropped. valid is a single-cycle strobe with no
// backpressure; match and match_index stay stable until the next strobe.
interface sme_param_if #(
  parameter int CHAR_W = 8,
  parameter int IDX_W  = 5
);
  logic [CHAR_W-1:0] chardata;
  logic              isstring;
  logic              ispattern;
  logic              match;
  logic [IDX_W-1:0]  match_index;
  logic              valid;
  logic              busy;

  modport master (
    output chardata, isstring, ispattern,
    input  match, match_index, valid, busy
  );

  modport slave (
    input  chardata, isstring, ispattern,
    output match, match_index, valid, busy
  );
endinterface

// File: rtl/sme_param_window_cmp.sv
// sme_window_cmp: combinational test of one candidate start position.
//   win        string characters at s .. s+PAT_MAX (0 past the buffer end)
//   prev_char  string character at s-1 (don't care when s_zero)
//   s_zero     candidate is the first string position
//   at_str_end s + core_len equals the stored string length
//   core       pattern with anchors stripped, core_len valid entries
//   lead/trail word-start / word-end anchors present
//   hit        candidate satisfies core, lead and trail conditions
// The length bound (s + core_len <= str_len) is checked by the caller.
module sme_window_cmp
  import sme_pkg::*;
#(
  parameter int PAT_MAX = 8,
  parameter int CHAR_W  = 8,
  parameter int PL_W    = $clog2(PAT_MAX + 1)
) (
  input  logic [PAT_MAX:0][CHAR_W-1:0]   win,
  input  logic [CHAR_W-1:0]              prev_char,
  input  logic                           s_zero,
  input  logic                           at_str_end,
  input  logic [PAT_MAX-1:0][CHAR_W-1:0] core,
  input  logic [PL_W-1:0]                core_len,
  input  logic                           lead,
  input  logic                           trail,
  output logic                           hit
);

  logic              core_ok;
  logic              lead_ok;
  logic              trail_ok;
  logic [CHAR_W-1:0] end_char;

  always_comb begin
    core_ok  = 1'b1;
    end_char = '0;
    // One comparator per pattern position; unused positions are ignored.
    for (int k = 0; k < PAT_MAX; k++) begin
      if (PL_W'(k) < core_len &&
          !is_code(32'(core[k]), CH_ANY) &&
          !char_eq(32'(core[k]), 32'(win[k])))
        core_ok = 1'b0;
    end
    // Character right after the core, used by the word-end anchor.
    for (int k = 0; k <= PAT_MAX; k++) begin
      if (PL_W'(k) == core_len) end_char = win[k];
    end
    lead_ok  = !lead  || s_zero     || char_eq(32'(prev_char), {24'h0, CH_SPACE});
    trail_ok = !trail || at_str_end || char_eq(32'(end_char),  {24'h0, CH_SPACE});
    hit      = core_ok && lead_ok && trail_ok;
  end

endmodule

// File: rtl/sme_param.sv
// sme_param: parametrised string-match engine.
// Loads a subject string and then a pattern byte-serially over the host
// interface, then tests one candidate start index per clock and reports the
// lowest matching index. Pattern meta-characters: '^' word start, '$' word
// end, '.' any character.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   bus        sme_param_if slave modport (chardata/isstring/ispattern in,
//              match/match_index/valid/busy out)
//   state_dbg  current FSM state
// Build option: SME_CASE_FOLD_EN enables ASCII case-insensitive compare.
module sme_param
  import sme_pkg::*;
#(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int CHAR_W  = 8,
  parameter int IDX_W   = $clog2(STR_MAX)
) (
  input  logic        clk,
  input  logic        reset,
  sme_param_if.slave  bus,
  output sme_state_e  state_dbg
);

  localparam int SL_W  = IDX_W + 1;             // string length / candidate
  localparam int PL_W  = $clog2(PAT_MAX + 1);   // pattern length
  localparam int PI_W  = $clog2(PAT_MAX);       // pattern buffer index
  localparam int SUM_W = ((SL_W > PL_W) ? SL_W : PL_W) + 1;  // s+len, no wrap

  localparam logic [SL_W-1:0]  STR_MAX_L = SL_W'(STR_MAX);
  localparam logic [PL_W-1:0]  PAT_MAX_L = PL_W'(PAT_MAX);
  localparam logic [SUM_W-1:0] STR_MAX_S = SUM_W'(STR_MAX);

  sme_state_e state_q, state_d;

  logic [CHAR_W-1:0] str_buf [STR_MAX];
  logic [CHAR_W-1:0] pat_buf [PAT_MAX];
  logic [SL_W-1:0]   str_len;
  logic [PL_W-1:0]   pat_len;
  logic [SL_W-1:0]   s_q;
  logic              match_q;
  logic [IDX_W-1:0]  match_index_q;

  logic              str_we, pat_we;
  logic [IDX_W-1:0]  str_waddr;
  logic [PI_W-1:0]   pat_waddr;

  logic                           lead, trail;
  logic [PI_W-1:0]                last_idx;
  logic [PL_W-1:0]                core_len;
  logic [PAT_MAX-1:0][CHAR_W-1:0] core;
  logic [PAT_MAX:0][CHAR_W-1:0]   win;
  logic [CHAR_W-1:0]              prev_char;
  logic [SUM_W-1:0]               span_end;
  logic                           at_str_end;
  logic                           search_end;
  logic                           hit;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.isstring)       state_d = LOAD_STR;
        else if (bus.ispattern) state_d = LOAD_PAT;
      end
      LOAD_STR: begin
        if (bus.isstring)       state_d = LOAD_STR;
        else if (bus.ispattern) state_d = LOAD_PAT;
        else                    state_d = IDLE;
      end
      LOAD_PAT: begin
        if (!bus.ispattern) state_d = SEARCH;
      end
      SEARCH: begin
        if (search_end || hit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.busy        = (state_q == SEARCH) || (state_q == DONE);
    bus.valid       = (state_q == DONE);
    bus.match       = match_q;
    bus.match_index = match_index_q;
    state_dbg       = state_q;
  end

  // ---------------- buffer write control ----------------
  // The first character of a string or pattern always lands in slot 0.
  always_comb begin
    str_we    = 1'b0;
    str_waddr = '0;
    pat_we    = 1'b0;
    pat_waddr = '0;
    case (state_q)
      IDLE: begin
        if (bus.isstring)       str_we = 1'b1;
        else if (bus.ispattern) pat_we = 1'b1;
      end
      LOAD_STR: begin
        if (bus.isstring) begin
          if (str_len < STR_MAX_L) begin
            str_we    = 1'b1;
            str_waddr = str_len[IDX_W-1:0];
          end
        end else if (bus.ispattern) begin
          pat_we = 1'b1;
        end
      end
      LOAD_PAT: begin
        if (bus.ispattern && pat_len < PAT_MAX_L) begin
          pat_we    = 1'b1;
          pat_waddr = pat_len[PI_W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (str_we) str_buf[str_waddr] <= bus.chardata;
    if (pat_we) pat_buf[pat_waddr] <= bus.chardata;
  end

  // ---------------- counters and result registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      str_len       <= '0;
      pat_len       <= '0;
      s_q           <= '0;
      match_q       <= 1'b0;
      match_index_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.isstring)       str_len <= SL_W'(1);
          else if (bus.ispattern) pat_len <= PL_W'(1);
        end
        LOAD_STR: begin
          if (bus.isstring) begin
            if (str_len < STR_MAX_L) str_len <= str_len + SL_W'(1);
          end else if (bus.ispattern) begin
            pat_len <= PL_W'(1);
          end
        end
        LOAD_PAT: begin
          if (bus.ispattern) begin
            if (pat_len < PAT_MAX_L) pat_len <= pat_len + PL_W'(1);
          end else begin
            s_q <= '0;
          end
        end
        SEARCH: begin
          if (search_end) begin
            match_q       <= 1'b0;
            match_index_q <= '0;
          end else if (hit) begin
            match_q       <= 1'b1;
            match_index_q <= s_q[IDX_W-1:0];
          end else begin
            s_q <= s_q + SL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- pattern decode ----------------
  always_comb begin
    last_idx = PI_W'(pat_len - PL_W'(1));
    lead     = (pat_len != '0) && is_code(32'(pat_buf[0]), CH_START);
    // A lone '^' is a lead anchor, never also a trail anchor.
    trail    = (pat_len != '0) && is_code(32'(pat_buf[last_idx]), CH_END) &&
               (pat_len > PL_W'(lead));
    core_len = pat_len - PL_W'(lead) - PL_W'(trail);
    for (int k = 0; k < PAT_MAX - 1; k++) begin
      core[k] = lead ? pat_buf[k + 1] : pat_buf[k];
    end
    core[PAT_MAX-1] = lead ? '0 : pat_buf[PAT_MAX-1];
  end

  // ---------------- string window at candidate s ----------------
  always_comb begin : window
    logic [SUM_W-1:0] idx;
    idx = '0;
    for (int k = 0; k <= PAT_MAX; k++) begin
      idx    = SUM_W'(s_q) + SUM_W'(k);
      win[k] = (idx < STR_MAX_S) ? str_buf[idx[IDX_W-1:0]] : '0;
    end
    prev_char  = (s_q != '0) ? str_buf[IDX_W'(s_q - SL_W'(1))] : '0;
    span_end   = SUM_W'(s_q) + SUM_W'(core_len);
    at_str_end = (span_end == SUM_W'(str_len));
    // No candidate left (or nothing to search): finish with no match.
    search_end = (core_len == '0) || (str_len == '0) ||
                 (span_end > SUM_W'(str_len));
  end

  sme_window_cmp #(
    .PAT_MAX (PAT_MAX),
    .CHAR_W  (CHAR_W),
    .PL_W    (PL_W)
  ) u_window_cmp (
    .win        (win),
    .prev_char  (prev_char),
    .s_zero     (s_q == '0),
    .at_str_end (at_str_end),
    .core       (core),
    .core_len   (core_len),
    .lead       (lead),
    .trail      (trail),
    .hit        (hit)
  );

endmodule

// File: tb/tb_sme_param.sv
// Directed bench for sme_param: hand-computed match results and result
// latencies for a set of patterns against "hello world", string overflow,
// string reuse, reset during search, and the case-fold build option.
module tb_sme_param;
  import sme_pkg::*;

  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;
  localparam int CHAR_W  = 8;
  localparam int IDX_W   = 5;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  sme_state_e state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  sme_param_if #(.CHAR_W(CHAR_W), .IDX_W(IDX_W)) bus ();

  sme_param #(
    .STR_MAX (STR_MAX),
    .PAT_MAX (PAT_MAX),
    .CHAR_W  (CHAR_W),
    .IDX_W   (IDX_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Leaves isstring high so a following pattern can chain directly.
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      bus.isstring  = 1'b1;
      bus.ispattern = 1'b0;
      bus.chardata  = s[i];
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.isstring  = 1'b0;
    bus.ispattern = 1'b0;
    bus.chardata  = '0;
  endtask

  // Ends with the first non-pattern cycle driven.
  task automatic send_pat(input string p);
    for (int i = 0; i < p.len(); i++) begin
      @(negedge clk);
      bus.isstring  = 1'b0;
      bus.ispattern = 1'b1;
      bus.chardata  = p[i];
    end
    idle_cycle();
  endtask

  // Latency is counted in rising edges after the first non-pattern cycle.
  task automatic expect_result(input string tag, input logic exp_m,
                               input int exp_i, input int exp_lat);
    int   lat;
    logic got;
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) chk({tag, " busy"}, 32'(bus.busy), 32'd1);
      if (bus.valid) begin
        lat = c;
        got = 1'b1;
        break;
      end
    end
    chk({tag, " valid"}, 32'(got), 32'd1);
    chk({tag, " match"}, 32'(bus.match), 32'(exp_m));
    chk({tag, " index"}, 32'(bus.match_index), 32'(exp_i));
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    @(posedge clk);
    #1;
    chk({tag, " valid_drop"}, 32'(bus.valid), 32'd0);
    chk({tag, " match_hold"}, 32'(bus.match), 32'(exp_m));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    string long_s;
    bus.chardata  = '0;
    bus.isstring  = 1'b0;
    bus.ispattern = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst valid", 32'(bus.valid), 32'd0);
    chk("rst busy",  32'(bus.busy),  32'd0);
    chk("rst match", 32'(bus.match), 32'd0);
    chk("rst index", 32'(bus.match_index), 32'd0);
    chk("rst state", 32'(state_dbg), 32'(IDLE));
    reset = 1'b1;

    // Plain core match
    send_str("hello world");
    idle_cycle();
    send_pat("wor");
    expect_result("wor", 1'b1, 6, 8);

    // Anchors against the stored string
    send_pat("^wor");
    expect_result("^wor", 1'b1, 6, 8);
    send_pat("^orl");
    expect_result("^orl", 1'b0, 0, 11);
    send_pat("lo$");
    expect_result("lo$", 1'b1, 3, 5);
    send_pat("ld$");
    expect_result("ld$", 1'b1, 9, 11);

    // Wildcards, string chained straight into pattern, then string reuse
    send_str("hello world");
    send_pat("l.o");
    expect_result("l.o", 1'b1, 2, 4);
    send_pat("h...");
    expect_result("h...", 1'b1, 0, 2);

    // 40 characters offered, only the first 32 ('a') are stored
    long_s = "";
    for (int i = 0; i < 40; i++) long_s = {long_s, (i < 32) ? "a" : "z"};
    send_str(long_s);
    idle_cycle();
    send_pat("z");
    expect_result("overflow", 1'b0, 0, STR_MAX + 2);

    // Case folding
    send_str("hello world");
    idle_cycle();
    send_pat("WOR");
`ifdef SME_CASE_FOLD_EN
    expect_result("WOR", 1'b1, 6, 8);
`else
    expect_result("WOR", 1'b0, 0, 11);
`endif

    // Reset during search
    send_pat("wor");
    expect_result("wor2", 1'b1, 6, 8);
    send_pat("zzz");
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort busy",  32'(bus.busy),  32'd0);
    chk("abort valid", 32'(bus.valid), 32'd0);
    chk("abort match", 32'(bus.match), 32'd0);
    chk("abort index", 32'(bus.match_index), 32'd0);
    chk("abort state", 32'(state_dbg), 32'(IDLE));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("abort no_valid", 32'(bus.valid), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;

    // Stored string was invalidated by reset
    send_pat("h");
    expect_result("post_rst", 1'b0, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
